// File: rtl/fetch_redirect_arbiter_pkg.sv
// rtl/fetch_redirect_arbiter_pkg.sv - shared redirect-source and bubble-phase types
package fetch_redirect_arbiter_pkg;

    // Encoding is visible on the redirectSrc port: 0=none, 1=recovery, 2=rename, 3=interrupt.
    typedef enum logic [1:0] {
        SRC_NONE      = 2'd0,
        SRC_RECOVERY  = 2'd1,
        SRC_RENAME    = 2'd2,
        SRC_INTERRUPT = 2'd3
    } redirect_src_e;

    typedef enum logic {
        PHASE_FETCH = 1'b0,
        PHASE_WAIT  = 1'b1
    } phase_e;

endpackage

// File: rtl/fetch_bubble_fsm.sv
// rtl/fetch_bubble_fsm.sv - post-mispredict fetch bubble FSM with WAIT_DELAY-deep phase pipeline
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   recoveryReq         recovery redirect; forces every stage back to FETCH
//   brMispred           per-lane mispredicted branch result
//   sendBubble          bubble request to the next-PC stage
module fetch_bubble_fsm
    import fetch_redirect_arbiter_pkg::*;
#(
    parameter int INT_ISSUE_WIDTH = 2,
    parameter int WAIT_DELAY      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       recoveryReq,
    input  logic [INT_ISSUE_WIDTH-1:0] brMispred,
    output logic                       sendBubble
);

    // stage_q[0] is the current phase; later stages are delayed copies of it.
    phase_e stage_q [WAIT_DELAY];
    phase_e phase_next;

    // WAIT is sticky until a recovery redirect arrives.
    always_comb begin
        phase_next = stage_q[0];
        if (recoveryReq) begin
            phase_next = PHASE_FETCH;
        end else if (|brMispred) begin
            phase_next = PHASE_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WAIT_DELAY; i++) stage_q[i] <= PHASE_FETCH;
        end else if (recoveryReq) begin
            for (int i = 0; i < WAIT_DELAY; i++) stage_q[i] <= PHASE_FETCH;
        end else begin
            stage_q[0] <= phase_next;
            for (int i = 1; i < WAIT_DELAY; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    // Recovery drops the bubble in the same cycle so the redirected fetch is not gated.
    assign sendBubble = (stage_q[WAIT_DELAY-1] == PHASE_WAIT) && !recoveryReq;

endmodule

// File: rtl/fetch_redirect_arbiter.sv
// rtl/fetch_redirect_arbiter.sv - prioritised, registered PC-redirect arbiter for the next-PC stage
//
// Optional feature macro: RSD_STOP_FETCH_ON_PRED_MISS_EN (bubble FSM; sendBubble tied 0 when undefined).
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   recoveryReq/recoveryPC    recovery redirect (highest priority)
//   renameReq/renamePC        rename-stage mispredict redirect
//   intReq/intPC              interrupt pulse and vector (latched into a single-entry slot)
//   npStall                   next-PC stage stall (blocks only the interrupt)
//   brMispred                 per-lane mispredicted branch results
//   redirectValid/PC/Src      registered redirect to the next-PC stage
//   intAck                    one-cycle pulse when the interrupt is issued
//   intPending                interrupt latched and not yet issued
//   sendBubble                bubble injection request
module fetch_redirect_arbiter
    import fetch_redirect_arbiter_pkg::*;
#(
    parameter int PC_WIDTH        = 32,
    parameter int INT_ISSUE_WIDTH = 2,
    parameter int WAIT_DELAY      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       recoveryReq,
    input  logic [PC_WIDTH-1:0]        recoveryPC,
    input  logic                       renameReq,
    input  logic [PC_WIDTH-1:0]        renamePC,
    input  logic                       intReq,
    input  logic [PC_WIDTH-1:0]        intPC,
    input  logic                       npStall,
    input  logic [INT_ISSUE_WIDTH-1:0] brMispred,
    output logic                       redirectValid,
    output logic [PC_WIDTH-1:0]        redirectPC,
    output logic [1:0]                 redirectSrc,
    output logic                       intAck,
    output logic                       intPending,
    output logic                       sendBubble
);

    redirect_src_e       src_q;
    logic [PC_WIDTH-1:0] int_pc_q;
    logic                int_issue;

    // Flushes bypass npStall because the next-PC stage loads its PC from outside even while stalled.
    assign int_issue = intPending && !recoveryReq && !renameReq && !npStall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirectValid <= 1'b0;
            redirectPC    <= '0;
            src_q         <= SRC_NONE;
            intAck        <= 1'b0;
            intPending    <= 1'b0;
            int_pc_q      <= '0;
        end else begin
            intAck <= int_issue;

            // A rename request colliding with recovery is dropped, never queued.
            if (recoveryReq) begin
                redirectValid <= 1'b1;
                redirectPC    <= recoveryPC;
                src_q         <= SRC_RECOVERY;
            end else if (renameReq) begin
                redirectValid <= 1'b1;
                redirectPC    <= renamePC;
                src_q         <= SRC_RENAME;
            end else if (int_issue) begin
                redirectValid <= 1'b1;
                redirectPC    <= int_pc_q;
                src_q         <= SRC_INTERRUPT;
            end else begin
                redirectValid <= 1'b0;
                src_q         <= SRC_NONE;
            end

            // A new request wins over the clear so an interrupt arriving while the old one issues is kept.
            if (intReq) begin
                intPending <= 1'b1;
                int_pc_q   <= intPC;
            end else if (int_issue) begin
                intPending <= 1'b0;
            end
        end
    end

    assign redirectSrc = src_q;

`ifdef RSD_STOP_FETCH_ON_PRED_MISS_EN
    fetch_bubble_fsm #(
        .INT_ISSUE_WIDTH (INT_ISSUE_WIDTH),
        .WAIT_DELAY      (WAIT_DELAY)
    ) u_bubble (
        .clk         (clk),
        .rst         (rst),
        .recoveryReq (recoveryReq),
        .brMispred   (brMispred),
        .sendBubble  (sendBubble)
    );
`else
    logic unused_br_mispred;
    assign unused_br_mispred = ^brMispred;
    assign sendBubble        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_redirect_arbiter.sv
// tb/tb_fetch_redirect_arbiter.sv - directed self-checking bench for fetch_redirect_arbiter
module tb_fetch_redirect_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        recoveryReq, renameReq, intReq, npStall;
    logic [31:0] recoveryPC, renamePC, intPC;
    logic [1:0]  brMispred;
    logic        redirectValid, intAck, intPending, sendBubble;
    logic [31:0] redirectPC;
    logic [1:0]  redirectSrc;

    int vectors     = 0;
    int miscompares = 0;

    fetch_redirect_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .recoveryReq   (recoveryReq),
        .recoveryPC    (recoveryPC),
        .renameReq     (renameReq),
        .renamePC      (renamePC),
        .intReq        (intReq),
        .intPC         (intPC),
        .npStall       (npStall),
        .brMispred     (brMispred),
        .redirectValid (redirectValid),
        .redirectPC    (redirectPC),
        .redirectSrc   (redirectSrc),
        .intAck        (intAck),
        .intPending    (intPending),
        .sendBubble    (sendBubble)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        recoveryReq = 0; renameReq = 0; intReq = 0; npStall = 0; brMispred = 2'b00;
        recoveryPC = 0; renamePC = 0; intPC = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        vectors++;
        if ({redirectValid, redirectPC, redirectSrc, intAck, intPending, sendBubble} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_initial: outputs=%h expected 0",
                     {redirectValid, redirectPC, redirectSrc, intAck, intPending, sendBubble});
        end
        rst = 1'b1;
        // Build state: a redirect in flight and an interrupt pending under stall.
        npStall = 1; recoveryReq = 1; recoveryPC = 32'h44; intReq = 1; intPC = 32'h80;
        step();
        recoveryReq = 0; intReq = 0;
        vectors++;
        if (intPending !== 1'b1 || redirectValid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_setup: intPending=%b redirectValid=%b expected 1 1", intPending, redirectValid);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({redirectValid, redirectPC, redirectSrc, intAck, intPending, sendBubble} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_async: outputs=%h expected 0",
                     {redirectValid, redirectPC, redirectSrc, intAck, intPending, sendBubble});
        end
        step();
        rst = 1'b1; npStall = 0;
        step();
        vectors++;
        if (intPending !== 1'b0 || redirectValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: intPending=%b redirectValid=%b expected 0 0", intPending, redirectValid);
        end
    endtask

    task automatic test_same_cycle_flush();
        recoveryReq = 1; recoveryPC = 32'h1000; renameReq = 1; renamePC = 32'h2000;
        step();
        recoveryReq = 0; renameReq = 0;
        vectors++;
        if (redirectValid !== 1'b1 || redirectPC !== 32'h1000 || redirectSrc !== 2'd1) begin
            miscompares++;
            $display("FAIL same_cycle: valid=%b pc=%h src=%0d expected 1 00001000 1", redirectValid, redirectPC, redirectSrc);
        end
        step();
        vectors++;
        if (redirectValid !== 1'b0 || redirectSrc !== 2'd0 || redirectPC !== 32'h1000) begin
            miscompares++;
            $display("FAIL same_cycle_no_rename: valid=%b pc=%h src=%0d expected 0 00001000 0", redirectValid, redirectPC, redirectSrc);
        end
    endtask

    task automatic test_int_stall();
        npStall = 1; intReq = 1; intPC = 32'h80;
        step();
        intReq = 0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (intPending !== 1'b1 || redirectValid !== 1'b0 || intAck !== 1'b0) begin
                miscompares++;
                $display("FAIL int_stall[%0d]: pending=%b valid=%b ack=%b expected 1 0 0", i, intPending, redirectValid, intAck);
            end
            if (i < 2) step();
        end
        npStall = 0;
        step();
        vectors++;
        if (redirectValid !== 1'b1 || redirectPC !== 32'h80 || redirectSrc !== 2'd3 || intAck !== 1'b1 || intPending !== 1'b0) begin
            miscompares++;
            $display("FAIL int_issue: valid=%b pc=%h src=%0d ack=%b pending=%b expected 1 00000080 3 1 0",
                     redirectValid, redirectPC, redirectSrc, intAck, intPending);
        end
        step();
        vectors++;
        if (redirectValid !== 1'b0 || intAck !== 1'b0) begin
            miscompares++;
            $display("FAIL int_once: valid=%b ack=%b expected 0 0", redirectValid, intAck);
        end
    endtask

    task automatic test_int_flush_collision();
        intReq = 1; intPC = 32'h80;
        step();
        intReq = 0;
        renameReq = 1; renamePC = 32'h3000;
        step();
        renameReq = 0;
        vectors++;
        if (redirectValid !== 1'b1 || redirectPC !== 32'h3000 || redirectSrc !== 2'd2 || intAck !== 1'b0 || intPending !== 1'b1) begin
            miscompares++;
            $display("FAIL int_defer: valid=%b pc=%h src=%0d ack=%b pending=%b expected 1 00003000 2 0 1",
                     redirectValid, redirectPC, redirectSrc, intAck, intPending);
        end
        step();
        vectors++;
        if (redirectValid !== 1'b1 || redirectPC !== 32'h80 || redirectSrc !== 2'd3 || intAck !== 1'b1) begin
            miscompares++;
            $display("FAIL int_after_flush: valid=%b pc=%h src=%0d ack=%b expected 1 00000080 3 1",
                     redirectValid, redirectPC, redirectSrc, intAck);
        end
        step();
    endtask

    task automatic test_int_relatch();
        npStall = 1; intReq = 1; intPC = 32'h80;
        step();
        intPC = 32'h84;           // overwrite while pending
        step();
        intReq = 0; npStall = 0;
        step();
        // Issue cycle decided here; a new request arrives at the same time.
        intReq = 1; intPC = 32'h90;
        vectors++;
        if (redirectValid !== 1'b1 || redirectPC !== 32'h84 || intAck !== 1'b1) begin
            miscompares++;
            $display("FAIL int_overwrite: valid=%b pc=%h ack=%b expected 1 00000084 1", redirectValid, redirectPC, intAck);
        end
        step();
        intReq = 0;
        vectors++;
        if (intPending !== 1'b1 || redirectValid !== 1'b0) begin
            miscompares++;
            $display("FAIL int_relatch_pending: pending=%b valid=%b expected 1 0", intPending, redirectValid);
        end
        step();
        vectors++;
        if (redirectValid !== 1'b1 || redirectPC !== 32'h90 || redirectSrc !== 2'd3 || intPending !== 1'b0) begin
            miscompares++;
            $display("FAIL int_relatch_issue: valid=%b pc=%h src=%0d pending=%b expected 1 00000090 3 0",
                     redirectValid, redirectPC, redirectSrc, intPending);
        end
        step();
    endtask

    task automatic test_stall_flush();
        npStall = 1; recoveryReq = 1; recoveryPC = 32'h400;
        step();
        recoveryReq = 0;
        vectors++;
        if (redirectValid !== 1'b1 || redirectPC !== 32'h400 || redirectSrc !== 2'd1) begin
            miscompares++;
            $display("FAIL stall_flush: valid=%b pc=%h src=%0d expected 1 00000400 1", redirectValid, redirectPC, redirectSrc);
        end
        npStall = 0;
        step();
    endtask

    task automatic test_bubble();
        brMispred = 2'b01;
        step();
        brMispred = 2'b00;
`ifdef RSD_STOP_FETCH_ON_PRED_MISS_EN
        vectors++;
        if (sendBubble !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_t1: sendBubble=%b expected 0", sendBubble);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (sendBubble !== 1'b1) begin
                miscompares++;
                $display("FAIL bubble_hold[%0d]: sendBubble=%b expected 1", i, sendBubble);
            end
        end
        recoveryReq = 1; recoveryPC = 32'h500;
        #1;
        vectors++;
        if (sendBubble !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_drop: sendBubble=%b expected 0", sendBubble);
        end
        step();
        recoveryReq = 0;
        step();
        vectors++;
        if (sendBubble !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble_after_recovery: sendBubble=%b expected 0", sendBubble);
        end
`else
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (sendBubble !== 1'b0) begin
                miscompares++;
                $display("FAIL bubble_disabled[%0d]: sendBubble=%b expected 0", i, sendBubble);
            end
            step();
        end
`endif
    endtask

    initial begin
        test_reset();
        test_same_cycle_flush();
        test_int_stall();
        test_int_flush_collision();
        test_int_relatch();
        test_stall_flush();
        test_bubble();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_arbiter.md
Name: fetch_redirect_arbiter

Overview:
- Sits between the recovery manager, the rename-stage recovery logic, the interrupt controller and the next-PC stage.
- Collects all PC-redirect requests, prioritises them and presents at most one registered redirect per cycle to the next-PC stage.
- Holds an interrupt request until it can be taken without colliding with a flush or a stall.
- Optionally gates fetch with a bubble request after a branch mispredict.

Parameters:
- PC_WIDTH, 32, width of a PC value (matches PC_Path).
- INT_ISSUE_WIDTH, 2, number of integer branch-result lanes.
- WAIT_DELAY, 2, cycles from mispredict detection to bubble assertion (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- recoveryReq  in  1  redirect from Rw/Cm recovery (toRecoveryPhase).
- recoveryPC  in  PC_WIDTH  target for recoveryReq.
- renameReq  in  1  redirect from rename-stage mispredict.
- renamePC  in  PC_WIDTH  target for renameReq.
- intReq  in  1  interrupt pulse.
- intPC  in  PC_WIDTH  interrupt vector.
- npStall  in  1  next-PC stage stall.
- brMispred  in  INT_ISSUE_WIDTH  per-lane valid and mispredicted branch result.
- redirectValid  out  1  registered: next-PC stage must load redirectPC this cycle.
- redirectPC  out  PC_WIDTH  registered target.
- redirectSrc  out  2  0=none, 1=recovery, 2=rename, 3=interrupt.
- intAck  out  1  one-cycle pulse when the interrupt is issued.
- intPending  out  1  an interrupt is latched and not yet issued.
- sendBubble  out  1  request bubble injection (npStageSendBubbleLower).

Behaviour:
- Reset (rst=0, async): redirectValid=0, redirectPC=0, redirectSrc=0, intAck=0, intPending=0, sendBubble=0, bubble FSM in FETCH.
- Priority per cycle: recovery > rename > pending interrupt.
- Flush redirects (recovery or rename):
  - Issued with 1-cycle latency, independent of npStall; the next-PC stage writes PC from outside even while stalled.
  - Same-cycle recovery and rename: recovery wins, and the rename request is dropped, not queued.
- Interrupt slot:
  - intReq sets intPending and latches intPC.
  - A second intReq while pending overwrites intPC; the slot holds a single entry.
  - Issued in the cycle after a cycle with intPending=1, no flush request and npStall=0. In that cycle redirectValid=1, redirectSrc=3 and intAck=1, and intPending clears.
  - A flush request in the same cycle defers the interrupt; it stays pending.
  - intReq arriving in the issue cycle re-latches and keeps intPending=1.
- With no request, redirectValid=0 and redirectSrc=0; redirectPC holds its last value.
- Only one redirect per cycle; redirectValid is never asserted two cycles in a row for the same request.

Optional Feature:
- Macro RSD_STOP_FETCH_ON_PRED_MISS_EN.
- Defined: bubble FSM with states FETCH and WAIT plus a WAIT_DELAY-deep shift register.
  - Any brMispred bit while no recoveryReq moves next phase to WAIT.
  - sendBubble = delayed phase is WAIT and !recoveryReq.
  - recoveryReq, or a flush of type recovery, returns all stages to FETCH in the next cycle.
- Undefined: sendBubble tied to 0 and the FSM is removed.

Decomposition:
- Shared package (FetchUnitTypes): RedirectSrc enum (NONE, RECOVERY, RENAME, INTERRUPT) and the bubble Phase enum.
- One sub-module, fetch_bubble_fsm, holding the optional FSM and shift register.

Test Plan:
- Reset mid-operation: intReq pending, then rst=0 -> all outputs 0 immediately; after release intPending=0.
- Same-cycle recovery and rename: recoveryReq=1 with recoveryPC=0x1000, renameReq=1 with renamePC=0x2000 -> next cycle redirectValid=1, redirectPC=0x1000, redirectSrc=1; no rename redirect follows.
- Interrupt under stall: intReq with intPC=0x80, npStall=1 for 3 cycles -> intPending=1 and no redirect. npStall drops -> next cycle redirectPC=0x80, redirectSrc=3, intAck=1.
- Interrupt colliding with a flush: intPending=1 and renameReq (0x3000) in the same cycle -> redirect 0x3000 (src 2). The following cycle issues interrupt 0x80 with intAck=1.
- Stall-independent flush: npStall=1 and recoveryReq with 0x400 -> redirectValid=1 on the next cycle.
- Optional feature: brMispred=01 at cycle t -> sendBubble=1 from t+2 until recoveryReq, then 0 the same cycle. With the macro undefined, sendBubble stays 0.
